e_mdu: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage of the pipelined CPU. It accepts one multiply, divide or HI/LO-move operation per start pulse and holds results in HI/LO until overwritten. Width and per-class latency are configurable. `busy` and `stall_req` drive the hazard controller, which stalls D-stage MDU instructions while an operation is in flight.

---
 rtl/e_mdu_if.sv | 32 +++
 rtl/e_mdu.sv | 191 +++++++++++++++++++
 tb/tb_e_mdu.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - request/result bundle between the E stage and the multiply/divide unit
//
// Signals:
//   start     - one-cycle request strobe, qualifies op/a/b
//   op        - operation code (see e_mdu)
//   a, b      - forwarded rs/rt operands
//   busy      - operation in flight (registered)
//   stall_req - hazard request to the pipeline controller (combinational)
//   hi, lo    - HI/LO architectural registers
// Modports: master = pipeline side, slave = MDU side.
interface e_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             stall_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multi-cycle multiply/divide unit with HI/LO registers for the E stage
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   mdu    - e_mdu_if.slave: start/op/a/b in, busy/stall_req/hi/lo out
// Parameters:
//   WIDTH       - operand and HI/LO width (>= 2)
//   MULT_CYCLES - busy cycles for multiply-class ops (>= 1)
//   DIV_CYCLES  - busy cycles for divide-class ops (>= 1)
// Op codes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//   7..10 MADD/MADDU/MSUB/MSUBU when the macro MDU_MACC_EN is defined;
//   every other code is a no-op.
// The result is computed combinationally at the accepting edge and parked
// in a pending register; the busy period only models the pipeline latency.
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    e_mdu_if.slave  mdu
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MACC_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic [0:0] {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] pend_q, pend_d;
    // Cleared for divide-by-zero so the busy period runs but HI/LO stay put.
    logic               pend_wr_q, pend_wr_d;

    // ---------------------------------------------------------------
    // Op decode
    // ---------------------------------------------------------------
    logic is_mult, is_div, is_signed, is_macc, is_sub;

    always_comb begin
        is_mult   = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        is_macc   = 1'b0;
        is_sub    = 1'b0;
        case (mdu.op)
            OP_MULT:  begin is_mult = 1'b1; is_signed = 1'b1; end
            OP_MULTU: begin is_mult = 1'b1; end
            OP_DIV:   begin is_div  = 1'b1; is_signed = 1'b1; end
            OP_DIVU:  begin is_div  = 1'b1; end
`ifdef MDU_MACC_EN
            OP_MADD:  begin is_mult = 1'b1; is_macc = 1'b1; is_signed = 1'b1; end
            OP_MADDU: begin is_mult = 1'b1; is_macc = 1'b1; end
            OP_MSUB:  begin is_mult = 1'b1; is_macc = 1'b1; is_sub = 1'b1; is_signed = 1'b1; end
            OP_MSUBU: begin is_mult = 1'b1; is_macc = 1'b1; is_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Multiply: operands extended to 2*WIDTH so one unsigned multiplier
    // yields the signed or unsigned product modulo 2^(2*WIDTH).
    // ---------------------------------------------------------------
    logic [2*WIDTH-1:0] a_ext, b_ext, product, hilo_cur, macc_res, mult_res;

    always_comb begin
        a_ext    = {{WIDTH{is_signed & mdu.a[WIDTH-1]}}, mdu.a};
        b_ext    = {{WIDTH{is_signed & mdu.b[WIDTH-1]}}, mdu.b};
        product  = a_ext * b_ext;
        hilo_cur = {hi_q, lo_q};
        macc_res = is_sub ? (hilo_cur - product) : (hilo_cur + product);
        mult_res = is_macc ? macc_res : product;
    end

    // ---------------------------------------------------------------
    // Divide on magnitudes, then restore signs. The most negative value
    // divided by -1 falls out naturally: its magnitude is 2^(WIDTH-1)
    // as an unsigned number, the quotient negates back to itself and
    // the remainder is 0.
    // ---------------------------------------------------------------
    logic               a_neg, b_neg, div_zero;
    logic [WIDTH-1:0]   abs_a, abs_b, divisor, uq, ur, quo, rem;
    logic [2*WIDTH-1:0] div_res;

    always_comb begin
        a_neg    = is_signed & mdu.a[WIDTH-1];
        b_neg    = is_signed & mdu.b[WIDTH-1];
        div_zero = (mdu.b == '0);
        abs_a    = a_neg ? -mdu.a : mdu.a;
        abs_b    = b_neg ? -mdu.b : mdu.b;
        // Keep the divider defined for b == 0; the result is discarded then.
        divisor  = div_zero ? WIDTH'(1) : abs_b;
        uq       = abs_a / divisor;
        ur       = abs_a % divisor;
        quo      = (a_neg ^ b_neg) ? -uq : uq;
        rem      = a_neg ? -ur : ur;
        div_res  = {rem, quo};
    end

    // ---------------------------------------------------------------
    // Control FSM: next state and register updates
    // ---------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            S_IDLE: begin
                if (mdu.start) begin
                    if (is_mult || is_div) begin
                        state_d   = S_BUSY;
                        cnt_d     = is_mult ? MULT_LOAD : DIV_LOAD;
                        pend_d    = is_mult ? mult_res : div_res;
                        pend_wr_d = is_mult | ~div_zero;
                    end else if (mdu.op == OP_MTHI) begin
                        hi_d = mdu.a;
                    end else if (mdu.op == OP_MTLO) begin
                        lo_d = mdu.a;
                    end
                end
            end
            S_BUSY: begin
                // Requests arriving here are dropped; the hazard unit
                // is expected to hold them back via stall_req.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d   = S_IDLE;
                    pend_wr_d = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_q[2*WIDTH-1:WIDTH];
                        lo_d = pend_q[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign mdu.busy      = (state_q == S_BUSY);
    assign mdu.stall_req = (state_q == S_BUSY) | (mdu.start & (is_mult | is_div));
    assign mdu.hi        = hi_q;
    assign mdu.lo        = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - self-checking bench for e_mdu (vector table + scoreboard)
module tb_e_mdu;

    logic clk;
    logic reset;

    e_mdu_if #(.WIDTH(32)) ifc ();

    e_mdu #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          ncyc;
    } vec_t;

    vec_t        vecs[15];
    logic [63:0] sb_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op, count busy cycles, then pop the scoreboard and compare HI/LO.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int ncyc, input string name);
        int          cnt;
        logic [63:0] exp;
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.op    = op;
        ifc.a     = a;
        ifc.b     = b;
        #1;
        check({name, " stall_req"}, 64'(ifc.stall_req), (ncyc > 0) ? 64'd1 : 64'd0);
        sb_q.push_back({eh, el});
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.op    = 4'd0;
        ifc.a     = ~a;
        ifc.b     = ~b;
        cnt = 0;
        while (ifc.busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        check({name, " busy_cycles"}, 64'(cnt), 64'(ncyc));
        if (sb_q.size() == 0) begin
            check({name, " scoreboard"}, 64'd0, 64'd1);
        end else begin
            exp = sb_q.pop_front();
            check({name, " hi"}, 64'(ifc.hi), 64'(exp[63:32]));
            check({name, " lo"}, 64'(ifc.lo), 64'(exp[31:0]));
        end
    endtask

    initial begin
        int          cnt;
        logic [63:0] exp;

        vecs[0]  = '{4'd1,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2]  = '{4'd1,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
        vecs[3]  = '{4'd2,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vecs[4]  = '{4'd3,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[5]  = '{4'd4,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
        vecs[6]  = '{4'd3,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[8]  = '{4'd4,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 10};
        vecs[9]  = '{4'd5,  32'h00001234, 32'd0,        32'h00001234, 32'h0FFFFFFF, 0};
        vecs[10] = '{4'd4,  32'd5,        32'd0,        32'h00001234, 32'h0FFFFFFF, 10};
        vecs[11] = '{4'd6,  32'h00000055, 32'd9,        32'h00001234, 32'h00000055, 0};
        vecs[12] = '{4'd0,  32'hDEADBEEF, 32'd9,        32'h00001234, 32'h00000055, 0};
        vecs[13] = '{4'd15, 32'hDEADBEEF, 32'd9,        32'h00001234, 32'h00000055, 0};
        vecs[14] = '{4'd3,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};

        reset     = 1'b0;
        ifc.start = 1'b0;
        ifc.op    = 4'd0;
        ifc.a     = '0;
        ifc.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(ifc.busy), 64'd0);
        check("reset hi", 64'(ifc.hi), 64'd0);
        check("reset lo", 64'(ifc.lo), 64'd0);
        check("reset stall_req", 64'(ifc.stall_req), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el,
                   vecs[i].ncyc, $sformatf("vec%0d", i));
        end

`ifdef MDU_MACC_EN
        run_op(4'd6,  32'd10, 32'd0,  32'h00001234, 32'd10,       0, "mtlo10");
        run_op(4'd5,  32'd0,  32'd0,  32'h00000000, 32'd10,       0, "mthi0");
        run_op(4'd7,  32'd4,  32'd5,  32'h00000000, 32'd30,       5, "madd");
        run_op(4'd9,  32'd2,  32'd3,  32'h00000000, 32'd24,       5, "msub");
        run_op(4'd10, 32'd1,  32'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, "msubu");
        run_op(4'd8,  32'd1,  32'd1,  32'h00000000, 32'h00000000, 5, "maddu");
`else
        run_op(4'd7,  32'd4,  32'd5,  32'h00001234, 32'h00000055, 0, "op7 none");
        run_op(4'd10, 32'd4,  32'd5,  32'h00001234, 32'h00000055, 0, "op10 none");
`endif

        // DIV with a MULTU request on its 2nd busy cycle: the request is dropped.
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.op    = vecs[14].op;
        ifc.a     = vecs[14].a;
        ifc.b     = vecs[14].b;
        sb_q.push_back({vecs[14].eh, vecs[14].el});
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.op    = 4'd0;
        cnt = 0;
        while (ifc.busy === 1'b1 && cnt < 200) begin
            cnt++;
            check($sformatf("collide stall_req c%0d", cnt), 64'(ifc.stall_req), 64'd1);
            if (cnt == 2) begin
                @(negedge clk);
                ifc.start = 1'b1;
                ifc.op    = 4'd2;
                ifc.a     = 32'd3;
                ifc.b     = 32'd3;
                #1;
                check("collide stall_req during start", 64'(ifc.stall_req), 64'd1);
            end
            @(posedge clk);
            #1;
            ifc.start = 1'b0;
            ifc.op    = 4'd0;
        end
        check("collide busy_cycles", 64'(cnt), 64'd10);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hX;
        check("collide hi", 64'(ifc.hi), 64'(exp[63:32]));
        check("collide lo", 64'(ifc.lo), 64'(exp[31:0]));
        repeat (7) @(posedge clk);
        #1;
        check("collide busy after", 64'(ifc.busy), 64'd0);
        check("collide hilo after", {ifc.hi, ifc.lo}, {32'd2, 32'd14});

        // Reset on the 3rd busy cycle of a MULT: immediate clear, no late write.
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.op    = 4'd1;
        ifc.a     = 32'd6;
        ifc.b     = 32'd7;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.op    = 4'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst pre busy", 64'(ifc.busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst async busy", 64'(ifc.busy), 64'd0);
        check("rst async hi", 64'(ifc.hi), 64'd0);
        check("rst async lo", 64'(ifc.lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rst after busy", 64'(ifc.busy), 64'd0);
        check("rst after hilo", {ifc.hi, ifc.lo}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
